// File: rtl/tea_pkg.sv
// Shared TEA definitions for the encryptor and decryptor: word width, round constants and FSM states.
package tea_pkg;

    localparam int              TEA_W      = 8;
    localparam logic [TEA_W-1:0] TEA_DELTA  = 8'hB7;
    localparam int              TEA_ROUNDS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tea_state_e;

    // Sum left behind by the encryptor after all rounds, i.e. the first sum the decryptor uses.
    function automatic logic [TEA_W-1:0] tea_sum_init(input logic [TEA_W-1:0] delta,
                                                      input int              rounds);
        logic [15:0] prod;
        prod = 16'(delta) * 16'(rounds);
        return prod[TEA_W-1:0];
    endfunction

endpackage

// File: rtl/tea_decrypt_core_round_inv.sv
// One combinational TEA inverse round: undo the v1 update first, then v0 using the recovered v1.
import tea_pkg::*;

module tea_round_inv (
    input  logic [TEA_W-1:0] v0,
    input  logic [TEA_W-1:0] v1,
    input  logic [TEA_W-1:0] sum,
    input  logic [TEA_W-1:0] key0,
    input  logic [TEA_W-1:0] key1,
    input  logic [TEA_W-1:0] key2,
    input  logic [TEA_W-1:0] key3,
    output logic [TEA_W-1:0] v0_n,
    output logic [TEA_W-1:0] v1_n
);

    logic [TEA_W-1:0] v1_mix;
    logic [TEA_W-1:0] v1_add;
    logic [TEA_W-1:0] v0_mix;
    logic [TEA_W-1:0] v0_add;

    // Encryptor computed x' = (x + add) ^ mix terms, so strip the xor terms then subtract.
    assign v1_mix = v1 ^ (v0 + sum) ^ ((v0 >> 5) + key3);
    assign v1_add = (v0 << 4) + key2;
    assign v1_n   = v1_mix - v1_add;

    assign v0_mix = v0 ^ (v1_n + sum) ^ ((v1_n >> 5) + key1);
    assign v0_add = (v1_n << 4) + key0;
    assign v0_n   = v0_mix - v0_add;

endmodule

// File: rtl/tea_decrypt_core.sv
// Sequential TEA decryptor: accepts a ciphertext pair and key, runs one inverse round per clock,
// and presents the plaintext pair on a valid/ready handshake.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a ciphertext block
//   RUN   | one inverse round per cycle, sum walks down from SUM_INIT
//   DONE  | out_valid high, plaintext held until out_ready
import tea_pkg::*;

module tea_decrypt_core #(
    parameter int               ROUNDS = TEA_ROUNDS,
    parameter logic [TEA_W-1:0] DELTA  = TEA_DELTA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TEA_W-1:0] c0,
    input  logic [TEA_W-1:0] c1,
    input  logic [TEA_W-1:0] key0,
    input  logic [TEA_W-1:0] key1,
    input  logic [TEA_W-1:0] key2,
    input  logic [TEA_W-1:0] key3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TEA_W-1:0] p0,
    output logic [TEA_W-1:0] p1,
    output logic             busy
);

    localparam logic [1:0]       S_IDLE   = 2'(IDLE);
    localparam logic [1:0]       S_RUN    = 2'(RUN);
    localparam logic [1:0]       S_DONE   = 2'(DONE);
    localparam int               CNT_W    = 6;
    localparam logic [CNT_W-1:0] LAST_CNT = 6'(ROUNDS - 1);
    localparam logic [TEA_W-1:0] SUM_INIT = tea_sum_init(DELTA, ROUNDS);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [TEA_W-1:0] v0_q;
    logic [TEA_W-1:0] v1_q;
    logic [TEA_W-1:0] sum_q;
    logic [TEA_W-1:0] k0_q;
    logic [TEA_W-1:0] k1_q;
    logic [TEA_W-1:0] k2_q;
    logic [TEA_W-1:0] k3_q;
    logic [TEA_W-1:0] p0_q;
    logic [TEA_W-1:0] p1_q;
    logic [TEA_W-1:0] v0_n;
    logic [TEA_W-1:0] v1_n;

    tea_round_inv u_round (
        .v0   (v0_q),
        .v1   (v1_q),
        .sum  (sum_q),
        .key0 (k0_q),
        .key1 (k1_q),
        .key2 (k2_q),
        .key3 (k3_q),
        .v0_n (v0_n),
        .v1_n (v1_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            v0_q  <= '0;
            v1_q  <= '0;
            sum_q <= '0;
            k0_q  <= '0;
            k1_q  <= '0;
            k2_q  <= '0;
            k3_q  <= '0;
            p0_q  <= '0;
            p1_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        v0_q  <= c0;
                        v1_q  <= c1;
                        k0_q  <= key0;
                        k1_q  <= key1;
                        k2_q  <= key2;
                        k3_q  <= key3;
                        sum_q <= SUM_INIT;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    v0_q  <= v0_n;
                    v1_q  <= v1_n;
                    sum_q <= sum_q - DELTA;
                    cnt   <= cnt + 1'b1;
                    // Output registers only change here so p0/p1 survive the next accept.
                    if (cnt == LAST_CNT) begin
                        p0_q  <= v0_n;
                        p1_q  <= v1_n;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign out_valid = (state == S_DONE);
    assign p0        = p0_q;
    assign p1        = p1_q;

endmodule

// File: tb/tb_tea_decrypt_core.sv
// Self-checking bench for tea_decrypt_core: plaintexts are encrypted by a plain-arithmetic TEA model
// and the decryptor must recover them, with handshake timing checked around each block.
module tb_tea_decrypt_core;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] c0, c1, key0, key1, key2, key3, p0, p1;

    logic       d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_busy;
    logic [7:0] d1_c0, d1_c1, d1_key0, d1_key1, d1_key2, d1_key3, d1_p0, d1_p1;

    int checks   = 0;
    int failures = 0;

    tea_decrypt_core dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .c0(c0), .c1(c1),
        .key0(key0), .key1(key1), .key2(key2), .key3(key3),
        .out_valid(out_valid), .out_ready(out_ready),
        .p0(p0), .p1(p1), .busy(busy)
    );

    tea_decrypt_core #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .c0(d1_c0), .c1(d1_c1),
        .key0(d1_key0), .key1(d1_key1), .key2(d1_key2), .key3(d1_key3),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .p0(d1_p0), .p1(d1_p1), .busy(d1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Encryptor written straight from the round equation with integer arithmetic mod 256.
    function automatic logic [15:0] tea_enc(input int a, input int b, input logic [31:0] kk,
                                            input int rounds);
        int k[4];
        int s;
        for (int i = 0; i < 4; i++) k[i] = int'(kk[8*i +: 8]);
        s = 0;
        for (int r = 0; r < rounds; r++) begin
            s = (s + 183) % 256;
            a = ((a + (b * 16) % 256 + k[0]) % 256) ^ ((b + s) % 256) ^ ((b / 32 + k[1]) % 256);
            b = ((b + (a * 16) % 256 + k[2]) % 256) ^ ((a + s) % 256) ^ ((a / 32 + k[3]) % 256);
        end
        return {8'(a), 8'(b)};
    endfunction

    task automatic scramble_inputs();
        c0   = 8'($urandom);
        c1   = 8'($urandom);
        key0 = 8'($urandom);
        key1 = 8'($urandom);
        key2 = 8'($urandom);
        key3 = 8'($urandom);
    endtask

    // Accept one block, then wait for out_valid; leaves the block sitting in DONE.
    task automatic run_block(input logic [7:0] a0, input logic [7:0] a1, input logic [31:0] kk,
                             output logic [7:0] r0, output logic [7:0] r1);
        int k;
        int bad;
        k = 0;
        while (!in_ready && k < 100) begin
            step();
            k++;
        end
        check("ready_before_accept", 32'(in_ready), 32'd1);
        c0 = a0;
        c1 = a1;
        {key3, key2, key1, key0} = kk;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        k   = 0;
        bad = 0;
        while (!out_valid && k < 100) begin
            if (!busy || in_ready) bad++;
            scramble_inputs();
            step();
            k++;
        end
        // Seen #1 after edges: out_valid visible after edge N+32, i.e. high at edge N+33.
        check("latency", 32'(k), 32'd32);
        check("busy_during_run", 32'(bad), 32'd0);
        r0 = p0;
        r1 = p1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("in_ready_after_consume", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    endtask

    initial begin : main
        logic [7:0]  a0, a1, r0, r1, s0, s1;
        logic [31:0] kk;
        logic [15:0] ct, ct_b, res[2];
        logic [7:0]  pa0, pa1, pb0, pb1;
        int k, bad, cyc, accepts, got, t_first, t_second;
        logic acc;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        c0 = 8'h00; c1 = 8'h00; key0 = 8'h00; key1 = 8'h00; key2 = 8'h00; key3 = 8'h00;
        d1_in_valid = 1'b0; d1_out_ready = 1'b0;
        d1_c0 = 8'h00; d1_c1 = 8'h00; d1_key0 = 8'h00; d1_key1 = 8'h00; d1_key2 = 8'h00; d1_key3 = 8'h00;
        step();
        step();
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_p", {16'd0, p0, p1}, 32'd0);
        check("reset_dut1", {d1_in_ready, d1_out_valid, d1_busy, d1_p0, d1_p1}, {1'b1, 18'd0});

        // Single-round instance: known vector then a random round trip.
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                kk = 32'h0; ct = 16'hB71B; a0 = 8'h00; a1 = 8'h00;
            end else begin
                kk = $urandom; a0 = 8'($urandom); a1 = 8'($urandom);
                ct = tea_enc(int'(a0), int'(a1), kk, 1);
            end
            {d1_c0, d1_c1} = ct;
            {d1_key3, d1_key2, d1_key1, d1_key0} = kk;
            d1_in_valid = 1'b1;
            step();
            d1_in_valid = 1'b0;
            k = 0;
            while (!d1_out_valid && k < 20) begin
                step();
                k++;
            end
            check("r1_latency", 32'(k), 32'd1);
            check("r1_plain", {16'd0, d1_p0, d1_p1}, {16'd0, a0, a1});
            d1_out_ready = 1'b1;
            step();
            d1_out_ready = 1'b0;
            check("r1_ready_after", 32'(d1_in_ready), 32'd1);
        end

        // Round trips with extremes first, then random.
        for (int i = 0; i < 256; i++) begin
            case (i)
                0:       begin a0 = 8'hFF; a1 = 8'hFF; kk = 32'hFFFF_FFFF; end
                1:       begin a0 = 8'h00; a1 = 8'h00; kk = 32'hFFFF_FFFF; end
                2:       begin a0 = 8'hFF; a1 = 8'h00; kk = 32'h0000_0000; end
                3:       begin a0 = 8'h00; a1 = 8'hFF; kk = 32'hFF00_FF00; end
                default: begin a0 = 8'($urandom); a1 = 8'($urandom); kk = $urandom; end
            endcase
            ct = tea_enc(int'(a0), int'(a1), kk, 32);
            run_block(ct[15:8], ct[7:0], kk, r0, r1);
            check("roundtrip", {16'd0, r0, r1}, {16'd0, a0, a1});
            consume();
        end

        // Backpressure: hold DONE for 10 cycles while wiggling inputs.
        a0 = 8'h5A; a1 = 8'hC3; kk = $urandom;
        ct = tea_enc(int'(a0), int'(a1), kk, 32);
        run_block(ct[15:8], ct[7:0], kk, r0, r1);
        check("bp_plain", {16'd0, r0, r1}, {16'd0, a0, a1});
        s0 = p0; s1 = p1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            scramble_inputs();
            step();
            if (p0 !== s0 || p1 !== s1 || out_valid !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        check("bp_stable", 32'(bad), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release", {29'd0, in_ready, out_valid, busy}, {29'd0, 3'b100});

        // Reset in the middle of a run, then a fresh block.
        kk = $urandom;
        ct = tea_enc(8'h11, 8'h22, kk, 32);
        {c0, c1} = ct;
        {key3, key2, key1, key0} = kk;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrun_reset", {13'd0, in_ready, out_valid, busy, p0, p1}, {13'd0, 3'b100, 16'd0});
        a0 = 8'($urandom); a1 = 8'($urandom); kk = $urandom;
        ct = tea_enc(int'(a0), int'(a1), kk, 32);
        run_block(ct[15:8], ct[7:0], kk, r0, r1);
        check("post_reset_plain", {16'd0, r0, r1}, {16'd0, a0, a1});
        consume();

        // Back-to-back with out_ready tied high.
        pa0 = 8'($urandom); pa1 = 8'($urandom); pb0 = 8'($urandom); pb1 = 8'($urandom);
        kk = $urandom;
        ct   = tea_enc(int'(pa0), int'(pa1), kk, 32);
        ct_b = tea_enc(int'(pb0), int'(pb1), kk, 32);
        {c0, c1} = ct;
        {key3, key2, key1, key0} = kk;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cyc = 0; accepts = 0; got = 0; t_first = 0; t_second = 0;
        res[0] = 16'h0; res[1] = 16'h0;
        while (got < 2 && cyc < 200) begin
            acc = in_ready && in_valid;
            step();
            cyc++;
            if (acc) begin
                accepts++;
                if (accepts == 1) begin
                    t_first = cyc;
                    {c0, c1} = ct_b;
                end else begin
                    t_second = cyc;
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                res[got] = {p0, p1};
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_results_seen", 32'(got), 32'd2);
        check("b2b_gap", 32'(t_second - t_first), 32'd34);
        check("b2b_first", {16'd0, res[0]}, {16'd0, pa0, pa1});
        check("b2b_second", {16'd0, res[1]}, {16'd0, pb0, pb1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
